// File: rtl/dac_pacer_pkg.sv
// Shared definitions for the DAC sample pacer: parameter defaults and the
// pacing FSM state encoding.
package dac_pacer_pkg;

  localparam int DATA_W_DEF  = 16;  // matches the AD5541 driver tx_data width
  localparam int BUSY_TO_DEF = 32;  // clk cycles allowed for dac_busy to rise after dv

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } pacer_state_t;

endpackage

// File: rtl/dac_sample_pacer_if.sv
// Stream and driver-side signals of the DAC sample pacer.
//   s_valid/s_data/s_ready : sample stream into the pacer
//   dv/tx_data             : one-cycle load strobe and sample to the SPI driver
//   dac_busy               : driver frame in progress (driver csn inverted)
// slave  = the pacer, master = sample source plus SPI driver.
interface dac_sample_pacer_if #(
  parameter int DATA_W = 16
);
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;
  logic              dac_busy;
  logic              dv;
  logic [DATA_W-1:0] tx_data;

  modport master (
    output s_valid, s_data, dac_busy,
    input  s_ready, dv, tx_data
  );

  modport slave (
    input  s_valid, s_data, dac_busy,
    output s_ready, dv, tx_data
  );
endinterface

// File: rtl/dac_sample_pacer_sync_fifo.sv
// Single-clock FIFO holding samples for the pacer.
//   clk, reset        : clock, synchronous active-high reset (pointers/level only)
//   wr_en, wr_data    : write request; ignored when full
//   rd_en, rd_data    : read request; ignored when empty; rd_data shows the head
//   full, empty, level: occupancy status
// DEPTH must be a power of 2 so the pointers wrap on their own.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_wr   = wr_en & ~full;
  assign do_rd   = rd_en & ~empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/dac_sample_pacer.sv
// Upstream feeder for the AD5541 SPI DAC driver. Buffers samples in a FIFO
// and issues one per rate tick as a one-cycle dv with tx_data, never starting
// a frame while the driver is busy.
//   clk, reset   : clock shared with the driver, synchronous active-high reset
//   enable       : 1 = pacing runs; 0 = rate counter held at 0
//   rate_div     : sample period is rate_div+1 clk cycles
//   clr_flags    : one-cycle pulse clearing the sticky flags
//   bus          : sample stream in, dv/tx_data out, dac_busy in
//   fifo_level   : FIFO occupancy
//   underrun     : sticky, a tick found the FIFO empty (last sample re-sent)
//   missed_tick  : sticky, a tick arrived while a frame was in progress
//   frame_err    : sticky, dac_busy did not rise within BUSY_TO after dv
// Build option DAC_PACER_TWOS_COMP_EN: samples are two's complement and the
// MSB is inverted on the way out (offset binary for the AD5541).
// BUSY_TO must be >= 2.
//
// state     | meaning
// IDLE      | waiting for a rate tick
// ISSUE     | dv high for this single cycle, tx_data already loaded
// WAIT_BUSY | waiting for the driver to raise dac_busy, timeout running
// WAIT_DONE | driver frame in flight, waiting for dac_busy to fall
module dac_sample_pacer
  import dac_pacer_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = 16,
  parameter int RATE_W     = 16,
  parameter int BUSY_TO    = BUSY_TO_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [RATE_W-1:0]             rate_div,
  input  logic                          clr_flags,
  dac_sample_pacer_if.slave             bus,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underrun,
  output logic                          missed_tick,
  output logic                          frame_err
);
  localparam int TO_W = $clog2(BUSY_TO) + 1;

  pacer_state_t      state;
  pacer_state_t      state_nxt;
  logic [RATE_W-1:0] rate_cnt;
  logic              tick;
  logic [TO_W-1:0]   to_cnt;
  logic [DATA_W-1:0] last_sample;

  logic              fifo_wr;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_rd_data;
  logic [DATA_W-1:0] pop_data;

  logic              pop;
  logic              dv_c;
  logic              to_load;
  logic              to_dec;
  logic              set_under;
  logic              set_ferr;
  logic              set_missed;

  // Rate counter: tick on count == rate_div, then wrap to 0.
  assign tick = enable && (rate_cnt == rate_div);

  always_ff @(posedge clk) begin
    if (reset || !enable) rate_cnt <= '0;
    else if (tick)        rate_cnt <= '0;
    else                  rate_cnt <= rate_cnt + 1'b1;
  end

  assign fifo_wr     = bus.s_valid & bus.s_ready;
  assign bus.s_ready = ~fifo_full;

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (fifo_wr),
    .wr_data (bus.s_data),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

`ifdef DAC_PACER_TWOS_COMP_EN
  assign pop_data = {~fifo_rd_data[DATA_W-1], fifo_rd_data[DATA_W-2:0]};
`else
  assign pop_data = fifo_rd_data;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    dv_c      = 1'b0;
    to_load   = 1'b0;
    to_dec    = 1'b0;
    set_under = 1'b0;
    set_ferr  = 1'b0;
    case (state)
      IDLE: begin
        if (tick) begin
          state_nxt = ISSUE;
          // An empty FIFO re-sends whatever tx_data already holds.
          if (fifo_empty) set_under = 1'b1;
          else            pop       = 1'b1;
        end
      end
      ISSUE: begin
        dv_c      = 1'b1;
        to_load   = 1'b1;
        state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (bus.dac_busy) begin
          state_nxt = WAIT_DONE;
        end else if (to_cnt == TO_W'(1)) begin
          // Terminal count lands the flag exactly BUSY_TO cycles after ISSUE.
          set_ferr  = 1'b1;
          state_nxt = IDLE;
        end else begin
          to_dec = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!bus.dac_busy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign set_missed  = tick && (state != IDLE);
  assign bus.dv      = dv_c;
  assign bus.tx_data = last_sample;

  // tx_data doubles as the last-sample register: it only changes on a pop.
  always_ff @(posedge clk) begin
    if (reset)    last_sample <= '0;
    else if (pop) last_sample <= pop_data;
  end

  always_ff @(posedge clk) begin
    if (reset)        to_cnt <= '0;
    else if (to_load) to_cnt <= TO_W'(BUSY_TO - 1);
    else if (to_dec)  to_cnt <= to_cnt - 1'b1;
  end

  // A set in the same cycle as clr_flags wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      underrun    <= 1'b0;
      missed_tick <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      if (set_under)      underrun <= 1'b1;
      else if (clr_flags) underrun <= 1'b0;
      if (set_missed)     missed_tick <= 1'b1;
      else if (clr_flags) missed_tick <= 1'b0;
      if (set_ferr)       frame_err <= 1'b1;
      else if (clr_flags) frame_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dac_sample_pacer.sv
// Bench for dac_sample_pacer: sample table pushed through a scoreboard queue,
// a driver busy model, and hand-written sequences for back-pressure, missed
// ticks, busy timeout and mid-frame reset.
module tb_dac_sample_pacer;

  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int RW    = 16;
  localparam int BTO   = 32;
  localparam int FRAME = 272;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [RW-1:0] rate_div;
  logic          clr_flags;
  logic [4:0]    fifo_level;
  logic          underrun;
  logic          missed_tick;
  logic          frame_err;

  dac_sample_pacer_if #(.DATA_W(DW)) bus();

  dac_sample_pacer #(
    .DATA_W     (DW),
    .FIFO_DEPTH (DEPTH),
    .RATE_W     (RW),
    .BUSY_TO    (BTO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .rate_div    (rate_div),
    .clr_flags   (clr_flags),
    .bus         (bus),
    .fifo_level  (fifo_level),
    .underrun    (underrun),
    .missed_tick (missed_tick),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] sb[$];
  logic [DW-1:0] mon_last = '0;
  logic          prev_dv  = 1'b0;
  bit            busy_en  = 1'b0;
  bit            abort    = 1'b0;

  typedef struct {
    logic [DW-1:0] din;
    logic [DW-1:0] exp_bin;
    logic [DW-1:0] exp_2c;
  } vec_t;
  vec_t vecs[6];

  function automatic logic [DW-1:0] exp_of(input logic [DW-1:0] d);
`ifdef DAC_PACER_TWOS_COMP_EN
    return d ^ 16'h8000;
`else
    return d;
`endif
  endfunction

  function automatic logic [DW-1:0] vec_exp(input vec_t v);
`ifdef DAC_PACER_TWOS_COMP_EN
    return v.exp_2c;
`else
    return v.exp_bin;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [DW-1:0] d, input logic [DW-1:0] e, input int budget);
    int n = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    while (!bus.s_ready && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (bus.s_ready) sb.push_back(e);
    else chk("push_timeout", 32'(bus.s_ready), 32'd1);
    @(negedge clk);
    bus.s_valid = 1'b0;
  endtask

  task automatic wait_dv(input int budget, output int at);
    int n = 0;
    @(negedge clk);
    while (bus.dv !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (bus.dv !== 1'b1) chk("dv_timeout", 32'(bus.dv), 32'd1);
    at = cyc;
  endtask

  // Scoreboard: every dv must carry the next pushed sample, or the previous
  // one again when nothing is queued.
  initial begin
    logic [DW-1:0] e;
    forever begin
      @(negedge clk);
      if (bus.dv === 1'b1) begin
        if (sb.size() > 0) begin
          e        = sb.pop_front();
          mon_last = e;
        end else begin
          e = mon_last;
        end
        chk("tx_data", 32'(bus.tx_data), 32'(e));
        chk("dv_pulse", 32'(prev_dv), 32'd0);
        chk("dv_while_busy", 32'(bus.dac_busy), 32'd0);
      end
      prev_dv = bus.dv;
    end
  end

  // Driver model: busy rises one clk after dv and lasts FRAME clk.
  initial begin
    bus.dac_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.dv === 1'b1 && busy_en) begin
        @(negedge clk);
        bus.dac_busy = 1'b1;
        for (int i = 0; i < FRAME; i++) begin
          @(negedge clk);
          if (abort) break;
        end
        bus.dac_busy = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int prev;
    reset       = 1'b1;
    enable      = 1'b0;
    rate_div    = 16'd299;
    clr_flags   = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    vecs[0] = '{16'h1234, 16'h1234, 16'h9234};
    vecs[1] = '{16'hABCD, 16'hABCD, 16'h2BCD};
    vecs[2] = '{16'h8000, 16'h8000, 16'h0000};
    vecs[3] = '{16'h7FFF, 16'h7FFF, 16'hFFFF};
    vecs[4] = '{16'h0000, 16'h0000, 16'h8000};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 16'h7FFF};

    repeat (3) @(negedge clk);
    chk("rst_s_ready", 32'(bus.s_ready), 32'd1);
    chk("rst_dv", 32'(bus.dv), 32'd0);
    chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    chk("rst_missed", 32'(missed_tick), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    reset   = 1'b0;
    busy_en = 1'b1;

    // Sample table at rate_div=299: one dv every 300 clk, data in order.
    for (int i = 0; i < 6; i++) push(vecs[i].din, vec_exp(vecs[i]), 4);
    chk("table_level", 32'(fifo_level), 32'd6);
    enable = 1'b1;
    prev   = 0;
    for (int i = 0; i < 6; i++) begin
      wait_dv(400, t);
      chk("table_underrun", 32'(underrun), 32'd0);
      if (i > 0) chk("dv_period_300", 32'(t - prev), 32'd300);
      prev = t;
    end

    // FIFO now empty: the next tick re-sends the last sample.
    wait_dv(400, t);
    chk("dv_period_300", 32'(t - prev), 32'd300);
    chk("underrun_set", 32'(underrun), 32'd1);
    chk("underrun_level", 32'(fifo_level), 32'd0);
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    chk("underrun_clr", 32'(underrun), 32'd0);

    // Fill to 16 with pacing stopped; the 17th waits for the first pop.
    enable = 1'b0;
    repeat (300) @(negedge clk);
    for (int i = 0; i < DEPTH; i++) push(DW'(16'h1000 + i), exp_of(DW'(16'h1000 + i)), 2);
    chk("full_level", 32'(fifo_level), 32'd16);
    chk("full_s_ready", 32'(bus.s_ready), 32'd0);
    bus.s_valid = 1'b1;
    bus.s_data  = 16'h2017;
    repeat (5) @(negedge clk);
    chk("full_hold_ready", 32'(bus.s_ready), 32'd0);
    chk("full_hold_level", 32'(fifo_level), 32'd16);
    enable = 1'b1;
    push(16'h2017, exp_of(16'h2017), 400);
    chk("refill_level", 32'(fifo_level), 32'd16);

    // Ticks every 100 clk against 272-clk frames: missed ticks, one dv per frame.
    rate_div = 16'd99;
    wait_dv(400, prev);
    for (int i = 0; i < 2; i++) begin
      wait_dv(400, t);
      chk("dv_period_frame", 32'(t - prev), 32'd300);
      prev = t;
    end
    chk("missed_set", 32'(missed_tick), 32'd1);

    // No busy response: frame_err exactly BUSY_TO cycles after ISSUE.
    enable = 1'b0;
    repeat (300) @(negedge clk);
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    chk("missed_clr", 32'(missed_tick), 32'd0);
    chk("ferr_clr", 32'(frame_err), 32'd0);
    busy_en = 1'b0;
    enable  = 1'b1;
    wait_dv(200, prev);
    repeat (BTO - 1) @(negedge clk);
    chk("ferr_early", 32'(frame_err), 32'd0);
    @(negedge clk);
    chk("ferr_at_timeout", 32'(frame_err), 32'd1);
    wait_dv(200, t);
    chk("dv_after_ferr", 32'(t - prev), 32'd100);
    chk("no_missed_ferr", 32'(missed_tick), 32'd0);

    // Reset while in WAIT_DONE.
    busy_en = 1'b1;
    wait_dv(200, t);
    repeat (10) @(negedge clk);
    abort = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_dv", 32'(bus.dv), 32'd0);
    chk("mid_rst_level", 32'(fifo_level), 32'd0);
    chk("mid_rst_ready", 32'(bus.s_ready), 32'd1);
    chk("mid_rst_tx", 32'(bus.tx_data), 32'd0);
    chk("mid_rst_underrun", 32'(underrun), 32'd0);
    chk("mid_rst_missed", 32'(missed_tick), 32'd0);
    chk("mid_rst_ferr", 32'(frame_err), 32'd0);
    sb.delete();
    mon_last = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    abort = 1'b0;

    // After reset the last-sample register is 0 and pacing resumes.
    rate_div = 16'd9;
    enable   = 1'b1;
    wait_dv(50, t);
    chk("post_rst_underrun", 32'(underrun), 32'd1);
    push(16'h5555, exp_of(16'h5555), 4);
    wait_dv(400, t);
    chk("post_rst_missed", 32'(missed_tick), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
